rf_write_tracer: RTL and testbench
==================================

// Module: rf_write_tracer
// PURPOSE
//   Captures every architectural register-file write (enable, address, data) into a FIFO.
//   Tags each write with a cycle timestamp and presents it on a valid/ready stream for the
//   debug UART / trace sink.
//   Sits directly downstream of the processor's regfile write port and runs on the regfile clock.
//   Hardware replacement for the simulation-only write shadow; usable on the board.
// PARAMETERS
//   DEPTH        16   FIFO entries; power of two, >= 2
//   TS_WIDTH     32   timestamp counter width
//   DROP_WIDTH   16   drop counter width (saturating)
// PORTS
//   clock           in   1               regfile clock; all logic on rising edge
//   reset           in   1               asynchronous, active-high
//   enable          in   1               capture enable; 0 = ignore writes
//   clear           in   1               sync clear of overflow and drop_count (FIFO untouched)
//   rf_we           in   1               regfile ctrl_writeEnable
//   rf_waddr        in   5               regfile ctrl_writeReg
//   rf_wdata        in   32              regfile data_writeReg
//   out_valid       out  1               head entry available
//   out_ready       in   1               sink accepts head entry
//   out_reg         out  5               head: register number
//   out_data        out  32              head: written value
//   out_ts          out  TS_WIDTH        head: capture timestamp
//   out_is_rstatus  out  1               head: out_reg == 30
//   level           out  $clog2(DEPTH)+1 entries held
//   overflow        out  1               sticky; a write was dropped
//   drop_count      out  DROP_WIDTH      dropped writes, saturates at all-ones
// BEHAVIOUR
//   - Reset: FIFO empty, pointers 0, ts counter 0, overflow 0, drop_count 0.
//     All out_* fields 0; out_valid 0; level 0.
//   - Capture condition, evaluated at edge N: enable & rf_we & (rf_waddr != 0).
//     Writes to r0 are never captured.
//   - Timestamp: free-running counter, +1 per edge, wraps modulo 2^TS_WIDTH.
//     The entry stores the pre-increment value at edge N.
//   - Show-ahead FIFO: a capture at edge N gives out_valid = 1 after edge N, with fields valid.
//     The head is stable while out_valid & !out_ready.
//   - Pop: out_valid & out_ready at an edge; the next entry or empty is visible after that edge.
//   - out_valid == (level != 0). A pop while empty is impossible by construction.
//   - Full, capture, no pop: entry dropped, overflow <= 1, drop_count +1 (saturating).
//   - Full, capture, and pop at the same edge: both occur; level stays DEPTH; no drop.
//   - Non-full, capture and pop at the same edge: level unchanged; order preserved.
//   - clear with a drop at the same edge: the drop wins (overflow = 1, drop_count = 1).
//   - Pointers are log2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
//   - Reset asserted mid-stream: everything returns to reset values immediately; in-flight entries are lost.
// CONFIGURATION
//   RF_TRACE_TIMESTAMP_EN
//     defined:   counter and per-entry ts storage built; out_ts as above.
//     undefined: no counter or ts storage; out_ts tied to 0; all other behaviour identical.
// STRUCTURE
//   Shared header rf_trace_defs.vh holds:
//     - RF_ADDR_W = 5, RF_DATA_W = 32, RSTATUS_REG = 30
//     - entry field offsets for the packed {ts, reg, data} word
//   Sub-module rf_trace_fifo (generic show-ahead FIFO: WIDTH, DEPTH; push/pop/full/empty/level).
//   Top level holds capture qualification, timestamp counter, overflow/drop logic, field unpack.
// TESTING
//   1. Reset, enable=1, write r5<=0x1234 at edge 10, out_ready=1
//      -> out_valid for 1 cycle: out_reg=5, out_data=0x1234, out_ts=10.
//   2. Write r0<=0xFFFF_FFFF, and r7 with enable=0
//      -> out_valid stays 0, level=0.
//   3. out_ready=0, 17 back-to-back writes r1..r17 (DEPTH=16)
//      -> level=16, overflow=1, drop_count=1; drain yields r1..r16 in order.
//   4. FIFO full, capture and pop at the same edge
//      -> level stays 16, no drop, popped entry is oldest, new entry last.
//   5. Write r30<=0x2 -> out_is_rstatus=1. Assert clear -> overflow=0, drop_count=0, level unchanged.
//   6. Reset asserted mid-drain with level=5 -> out_valid=0 and level=0 without waiting for an edge.
//      Rebuild without RF_TRACE_TIMESTAMP_EN -> out_ts=0 always.

Source files
------------

// File: rtl/rf_write_tracer_pkg.sv
// Shared register-file trace constants, capture bundle and packed entry field offsets.
package rf_write_tracer_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RSTATUS_REG = 30;

  // Packed entry word is {ts, reg, data}; ts is present only when timestamps are built.
  localparam int DATA_LSB     = 0;
  localparam int REG_LSB      = DATA_LSB + RF_DATA_W;
  localparam int TS_LSB       = REG_LSB + RF_ADDR_W;
  localparam int ENTRY_BASE_W = TS_LSB;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_trace_fifo.sv
// Generic show-ahead FIFO: head word visible combinationally, level tracks occupancy.
module rf_trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_q];

  // A push into a full FIFO is accepted only when the head leaves at the same edge.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rf_write_tracer.sv
// Register-file write tracer: qualifies writes, timestamps them and streams them out of a FIFO.
// Timestamp counter and per-entry ts storage exist only with RF_TRACE_TIMESTAMP_EN defined.
module rf_write_tracer
  import rf_write_tracer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 32,
  parameter int DROP_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      rf_we,
  input  logic [RF_ADDR_W-1:0]      rf_waddr,
  input  logic [RF_DATA_W-1:0]      rf_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RF_ADDR_W-1:0]      out_reg,
  output logic [RF_DATA_W-1:0]      out_data,
  output logic [TS_WIDTH-1:0]       out_ts,
  output logic                      out_is_rstatus,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [DROP_WIDTH-1:0]     drop_count
);
`ifdef RF_TRACE_TIMESTAMP_EN
  localparam int EW = ENTRY_BASE_W + TS_WIDTH;
`else
  localparam int EW = ENTRY_BASE_W;
`endif

  rf_wr_t          wr;
  logic [EW-1:0]   push_word, head_word;
  logic            capture, pop, full, empty, drop;
  logic            ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0] cnt_q, cnt_d;

  assign wr      = '{addr: rf_waddr, data: rf_wdata};
  assign capture = enable & rf_we & (rf_waddr != '0);
  assign pop     = out_valid & out_ready;
  assign drop    = capture & full & ~pop;

`ifdef RF_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign push_word = {ts_q, wr};
  assign out_ts    = out_valid ? head_word[TS_LSB +: TS_WIDTH] : '0;
`else
  assign push_word = wr;
  assign out_ts    = '0;
`endif

  rf_trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (head_word),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Fields are masked while empty so stale memory never shows and reset reads as zero.
  assign out_valid      = ~empty;
  assign out_reg        = out_valid ? head_word[REG_LSB +: RF_ADDR_W] : '0;
  assign out_data       = out_valid ? head_word[DATA_LSB +: RF_DATA_W] : '0;
  assign out_is_rstatus = out_valid & (out_reg == RF_ADDR_W'(RSTATUS_REG));

  // A drop outranks a same-edge clear: the drop is recorded on a freshly cleared count.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clear)            cnt_d = DROP_WIDTH'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (clear) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = cnt_q;

endmodule

// File: tb/tb_rf_write_tracer.sv
// Directed plus randomized bench for rf_write_tracer against a queue-based reference model.
module tb_rf_write_tracer;
  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] t;
  } ent_t;

  logic          clock = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
  logic          rf_we = 1'b0, out_ready = 1'b0;
  logic [4:0]    rf_waddr = '0;
  logic [31:0]   rf_wdata = '0;
  logic          out_valid, out_is_rstatus, overflow;
  logic [4:0]    out_reg;
  logic [31:0]   out_data, out_ts;
  logic [LW-1:0] level;
  logic [DW-1:0] drop_count;

  rf_write_tracer #(.DEPTH(DEPTH), .TS_WIDTH(32), .DROP_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg),
    .out_data(out_data), .out_ts(out_ts), .out_is_rstatus(out_is_rstatus),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_pass = 0;
  ent_t        q[$];
  logic [31:0] ts_m;
  logic        ovf_m;
  int          drop_m;
  logic [31:0] d17 [17];

  function automatic logic [31:0] exp_ts(input logic [31:0] t);
`ifdef RF_TRACE_TIMESTAMP_EN
    return t;
`else
    return 32'(t & 32'h0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, "_level"}, 64'(level), 64'(q.size()));
    chk({tag, "_ovf"},   64'(overflow), 64'(ovf_m));
    chk({tag, "_drops"}, 64'(drop_count), 64'(drop_m));
    if (q.size() != 0) begin
      chk({tag, "_reg"},  64'(out_reg), 64'(q[0].r));
      chk({tag, "_data"}, 64'(out_data), 64'(q[0].d));
      chk({tag, "_ts"},   64'(out_ts), 64'(exp_ts(q[0].t)));
      chk({tag, "_rst"},  64'(out_is_rstatus), 64'(q[0].r == 5'd30));
    end
  endtask

  // One clock: drive at negedge, apply the reference rules at the edge, check 1ns later.
  task automatic step(input string tag, input logic en, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic rdy, input logic clr);
    logic pop, cap, full;
    @(negedge clock);
    enable = en; rf_we = we; rf_waddr = a; rf_wdata = d; out_ready = rdy; clear = clr;
    pop  = (q.size() != 0) && rdy;
    cap  = en && we && (a != 5'd0);
    full = (q.size() == DEPTH);
    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (cap && full && !pop) begin
      ovf_m  = 1'b1;
      drop_m = clr ? 1 : ((drop_m + 1 > (1 << DW) - 1) ? (1 << DW) - 1 : drop_m + 1);
    end else begin
      if (cap) q.push_back('{r: a, d: d, t: ts_m});
      if (clr) begin ovf_m = 1'b0; drop_m = 0; end
    end
    ts_m = ts_m + 32'd1;
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete(); ts_m = '0; ovf_m = 1'b0; drop_m = 0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_reg",   64'(out_reg), 64'(0));
    chk("rst_data",  64'(out_data), 64'(0));
    chk("rst_ts",    64'(out_ts), 64'(0));
    chk("rst_ovf",   64'(overflow), 64'(0));
    chk("rst_drops", 64'(drop_count), 64'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Test 1: idle edges 0..9, r5 <= 0x1234 captured at edge 10.
    for (int i = 0; i < 10; i++) step("t1_idle", 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    step("t1_wr", 1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);
    chk("t1_reg",  64'(out_reg), 64'(5));
    chk("t1_data", 64'(out_data), 64'h1234);
    chk("t1_ts",   64'(out_ts), 64'(exp_ts(32'd10)));
    step("t1_pop", 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("t1_gone", 64'(out_valid), 64'(0));

    // Test 2: r0 and disabled writes are ignored.
    step("t2_r0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step("t2_dis", 1'b0, 1'b1, 5'd7, 32'h7777, 1'b1, 1'b0);
    chk("t2_level", 64'(level), 64'(0));

    // Test 3: 17 writes with sink stalled; the 17th drops.
    for (int i = 0; i < 17; i++) begin
      d17[i] = $urandom;
      step("t3_fill", 1'b1, 1'b1, 5'(i + 1), d17[i], 1'b0, 1'b0);
    end
    chk("t3_level", 64'(level), 64'(16));
    chk("t3_ovf",   64'(overflow), 64'(1));
    chk("t3_drops", 64'(drop_count), 64'(1));

    // Test 4: full, capture and pop together: no drop, oldest leaves, new one queued.
    step("t4_both", 1'b1, 1'b1, 5'd20, 32'hABCD, 1'b1, 1'b0);
    chk("t4_level", 64'(level), 64'(16));
    chk("t4_drops", 64'(drop_count), 64'(1));
    chk("t4_head",  64'(out_reg), 64'(2));
    for (int i = 0; i < 16; i++) step("t4_drain", 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_empty", 64'(level), 64'(0));

    // Test 5: rstatus flag, then clear leaves the FIFO alone.
    step("t5_r30", 1'b1, 1'b1, 5'd30, 32'h2, 1'b0, 1'b0);
    chk("t5_rst", 64'(out_is_rstatus), 64'(1));
    step("t5_clr", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("t5_ovf",   64'(overflow), 64'(0));
    chk("t5_drops", 64'(drop_count), 64'(0));
    chk("t5_level", 64'(level), 64'(1));

    // Saturation of the narrow drop counter, then clear colliding with a drop.
    for (int i = 0; i < 40; i++)
      step("sat", 1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0);
    chk("sat_drops", 64'(drop_count), 64'((1 << DW) - 1));
    step("clrdrop", 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    chk("clrdrop_ovf",   64'(overflow), 64'(1));
    chk("clrdrop_drops", 64'(drop_count), 64'(1));

    // Randomized traffic with phases of slow and fast draining.
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step("rnd", $urandom_range(0, 9) != 0, 1'($urandom), 5'($urandom), $urandom, rdy,
           $urandom_range(0, 40) == 0);
    end

    // Test 6: asynchronous reset with five entries held.
    for (int i = 0; i < 20; i++) step("t6_drain", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 1'b1, 5'(i + 3), $urandom, 1'b0, 1'b0);
    chk("t6_pre", 64'(level), 64'(5));
    @(negedge clock);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_ovf",   64'(overflow), 64'(0));
    chk("t6_drops", 64'(drop_count), 64'(0));
    chk("t6_reg",   64'(out_reg), 64'(0));
    chk("t6_ts",    64'(out_ts), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    step("t6_after", 1'b1, 1'b1, 5'd11, 32'h5A5A, 1'b0, 1'b0);
    chk("t6_ts0", 64'(out_ts), 64'(exp_ts(32'd0)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
